// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of the hazard controller's pipeline-facing signals.
//   master : pipeline side. Drives the hazard inputs (branch/trap/load-use/
//            mem_busy/redirect_ready/cnt_clr) and receives stall/flush/
//            redirect/perf outputs.
//   slave  : hazard controller side. The directions are the mirror image.
interface hazard_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 32
);
    logic              branch_taken_ex;
    logic [XLEN-1:0]   branch_target_ex;
    logic              trap_req;
    logic [XLEN-1:0]   trap_vector;
    logic              no_forwarding_data;
    logic              mem_busy;
    logic              redirect_ready;
    logic              cnt_clr;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              nop_issue;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_target;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  redirect_count;

    modport master (
        output branch_taken_ex, branch_target_ex, trap_req, trap_vector,
               no_forwarding_data, mem_busy, redirect_ready, cnt_clr,
        input  stall, flush, nop_issue, redirect_valid, redirect_target,
               stall_cycles, redirect_count
    );

    modport slave (
        input  branch_taken_ex, branch_target_ex, trap_req, trap_vector,
               no_forwarding_data, mem_busy, redirect_ready, cnt_clr,
        output stall, flush, nop_issue, redirect_valid, redirect_target,
               stall_cycles, redirect_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect controller for an NSTAGE in-order pipeline.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; all outputs read 0 while high
//   bus  - hazard_ctrl_if.slave: hazard inputs in; per-stage stall/flush,
//          issue NOP, fetch redirect and perf counters out
// Control outputs are combinational from state and inputs. State, the
// load-use extra-cycle counter, the pending redirect target and the perf
// counters are registered.
module hazard_ctrl #(
    parameter int XLEN      = 64,
    parameter int NSTAGE    = 5,
    parameter int ISSUE_IDX = 3,
    parameter int EX_IDX    = 4,
    parameter int LU_EXTRA  = 0,
    parameter int CNT_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_LU   = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [NSTAGE-1:0] ONE_N = {{(NSTAGE-1){1'b0}}, 1'b1};
    // Stages younger than EX are on the wrong path after a branch.
    localparam logic [NSTAGE-1:0] BR_MASK = (ONE_N << EX_IDX) - ONE_N;
    // A trap also kills the trapping instruction in EX itself.
    localparam logic [NSTAGE-1:0] TRAP_MASK =
        (EX_IDX + 1 >= NSTAGE) ? {NSTAGE{1'b1}} : ((ONE_N << (EX_IDX + 1)) - ONE_N);
    // Stages feeding the issue stage hold while it emits a bubble.
    localparam logic [NSTAGE-1:0] LU_MASK = (ONE_N << ISSUE_IDX) - ONE_N;
    localparam logic [3:0] LU_LOAD = 4'(LU_EXTRA);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [3:0]        lu_cnt_q, lu_cnt_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  redirect_count_q, redirect_count_d;

    logic [NSTAGE-1:0] stall_s;
    logic [NSTAGE-1:0] flush_s;
    logic              nop_s;
    logic              rv_s;
    logic [XLEN-1:0]   rt_s;

    // Priority decode of hazards into control outputs and next state.
    always_comb begin
        stall_s  = {NSTAGE{1'b0}};
        flush_s  = {NSTAGE{1'b0}};
        nop_s    = 1'b0;
        rv_s     = 1'b0;
        rt_s     = {XLEN{1'b0}};
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        pend_d   = pend_q;
        if (rst) begin
            // Outputs forced quiet while reset is held.
            state_d = ST_RUN;
        end else if (bus.mem_busy) begin
            // Whole-pipe freeze; the frozen stages re-present their hazards later.
            stall_s = {NSTAGE{1'b1}};
        end else if (state_q == ST_PEND) begin
            flush_s = BR_MASK;
            rv_s    = 1'b1;
            rt_s    = pend_q;
            if (bus.redirect_ready) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_PEND;
            end
        end else if (bus.trap_req || bus.branch_taken_ex) begin
            rv_s     = 1'b1;
            lu_cnt_d = 4'd0;
            if (bus.trap_req) begin
                flush_s = TRAP_MASK;
                rt_s    = bus.trap_vector;
            end else begin
                flush_s = BR_MASK;
                rt_s    = bus.branch_target_ex;
            end
            if (bus.redirect_ready) begin
                state_d = ST_RUN;
            end else begin
                pend_d  = rt_s;
                state_d = ST_PEND;
            end
        end else if (state_q == ST_LU) begin
            stall_s  = LU_MASK;
            nop_s    = 1'b1;
            lu_cnt_d = lu_cnt_q - 4'd1;
            if (lu_cnt_q <= 4'd1) begin
                lu_cnt_d = 4'd0;
                state_d  = ST_RUN;
            end else begin
                state_d  = ST_LU;
            end
        end else if (bus.no_forwarding_data) begin
            stall_s = LU_MASK;
            nop_s   = 1'b1;
            if (LU_LOAD != 4'd0) begin
                lu_cnt_d = LU_LOAD;
                state_d  = ST_LU;
            end else begin
                state_d  = ST_RUN;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // Saturating perf counters; clear wins over increment.
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (bus.cnt_clr) begin
            stall_cycles_d   = {CNT_W{1'b0}};
            redirect_count_d = {CNT_W{1'b0}};
        end else begin
            if ((|stall_s) && !(&stall_cycles_q)) begin
                stall_cycles_d = stall_cycles_q + CNT_ONE;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
            if (rv_s && bus.redirect_ready && !(&redirect_count_q)) begin
                redirect_count_d = redirect_count_q + CNT_ONE;
            end else begin
                redirect_count_d = redirect_count_q;
            end
        end
    end

    // State, load-use counter, pending target and perf counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            lu_cnt_q         <= 4'd0;
            pend_q           <= {XLEN{1'b0}};
            stall_cycles_q   <= {CNT_W{1'b0}};
            redirect_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q          <= state_d;
            lu_cnt_q         <= lu_cnt_d;
            pend_q           <= pend_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign bus.stall           = stall_s;
    assign bus.flush           = flush_s;
    assign bus.nop_issue       = nop_s;
    assign bus.redirect_valid  = rv_s;
    assign bus.redirect_target = rt_s;
    assign bus.stall_cycles    = stall_cycles_q;
    assign bus.redirect_count  = redirect_count_q;

endmodule
